// File: rtl/ad9764_writer.sv
// Parallel DAC writer: buffers handshaked samples in a small FIFO and replays them
// to the DAC one per divided conversion clock, changing data only on dac_clk falls.
module ad9764_writer #(
  parameter int                 DATA_W     = 12,
  parameter int                 DIV        = 3,
  parameter int                 DEPTH      = 4,
  parameter int                 LVL_W      = 3,
  parameter logic [DATA_W-1:0]  RESET_CODE = 12'h800
) (
  input  logic              clk,
  input  logic              CR,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              clr_underrun,
  output logic              dac_clk,
  output logic [DATA_W-1:0] dac_data,
  output logic              underrun,
  output logic [LVL_W-1:0]  level
);

  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic tick;
  logic pop;
  logic push;
  logic pop_ok;
  logic pop_empty;

  // Handshake: a sample transfers on every clk edge where din_valid && din_ready;
  // din_ready depends only on the level register, never on din_valid.
  assign din_ready = (level != LVL_FULL);
  assign push      = din_valid && din_ready;

  // A pop is the tick that drops dac_clk, so data moves a full half-period
  // away from the DAC's rising latch edge.
  assign tick      = (cnt == CNT_MAX);
  assign pop       = tick && dac_clk;
  assign pop_ok    = pop && (level != '0);
  assign pop_empty = pop && (level == '0);

  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      cnt      <= '0;
      dac_clk  <= 1'b0;
      dac_data <= RESET_CODE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      underrun <= 1'b0;
    end else begin
      if (tick) begin
        cnt     <= '0;
        dac_clk <= ~dac_clk;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop_ok) begin
        dac_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end

      case ({push, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // A fresh underrun takes priority over a clear in the same cycle.
      if (pop_empty) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

  // Storage needs no reset: reads are gated by level, which is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: tb/tb_ad9764_writer.sv
// Directed bench for ad9764_writer with DIV=3, DEPTH=4: reset timeline, streaming,
// backpressure, empty-push collision, underrun clear and mid-run reset.
module tb_ad9764_writer;

  logic        clk = 1'b0;
  logic        CR = 1'b1;
  logic [11:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        clr_underrun = 1'b0;
  logic        dac_clk;
  logic [11:0] dac_data;
  logic        underrun;
  logic [2:0]  level;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [11:0] exp_q[$];

  ad9764_writer #(
    .DATA_W(12), .DIV(3), .DEPTH(4), .LVL_W(3), .RESET_CODE(12'h800)
  ) dut (
    .clk(clk), .CR(CR), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .clr_underrun(clr_underrun), .dac_clk(dac_clk), .dac_data(dac_data),
    .underrun(underrun), .level(level)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // cyc = number of rising edges since the last reset release
  always @(posedge clk or posedge CR) begin
    if (CR) cyc <= 0;
    else    cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic reset_dut();
    @(negedge clk);
    CR = 1'b1;
    din_valid = 1'b0;
    clr_underrun = 1'b0;
    din = '0;
    repeat (2) @(negedge clk);
    CR = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 1000 && cyc < n; i++) @(negedge clk);
    n_cmp++;
    if (cyc !== n) begin
      n_bad++;
      $display("FAIL wait_cyc got=%0d exp=%0d", cyc, n);
    end
  endtask

  task automatic test_reset();
    logic exp_clk;
    reset_dut();
    n_cmp++; if (dac_clk !== 1'b0) begin n_bad++; $display("FAIL rst_dac_clk got=%b exp=0", dac_clk); end
    n_cmp++; if (dac_data !== 12'h800) begin n_bad++; $display("FAIL rst_dac_data got=%h exp=800", dac_data); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rst_level got=%0d exp=0", level); end
    n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL rst_din_ready got=%b exp=1", din_ready); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
    for (int k = 1; k <= 16; k++) begin
      wait_cyc(k);
      exp_clk = ((k / 3) % 2) == 1;
      n_cmp++; if (dac_clk !== exp_clk) begin n_bad++; $display("FAIL idle_dac_clk cyc=%0d got=%b exp=%b", k, dac_clk, exp_clk); end
      n_cmp++; if (underrun !== (k >= 6)) begin n_bad++; $display("FAIL idle_underrun cyc=%0d got=%b exp=%b", k, underrun, (k >= 6)); end
      n_cmp++; if (dac_data !== 12'h800) begin n_bad++; $display("FAIL idle_dac_data cyc=%0d got=%h exp=800", k, dac_data); end
      n_cmp++; if (level !== 3'd0 || din_ready !== 1'b1) begin n_bad++; $display("FAIL idle_level cyc=%0d got=%0d/%b exp=0/1", k, level, din_ready); end
    end
  endtask

  task automatic test_streaming();
    logic [11:0] next_val;
    logic [11:0] prev_data;
    logic [11:0] exp_v;
    logic        prev_clk;
    logic        pend_valid;
    logic        pend_ready;
    reset_dut();
    exp_q.delete();
    next_val = 12'h001;
    prev_data = dac_data;
    prev_clk = dac_clk;
    pend_valid = 1'b0;
    pend_ready = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      // the previous drive was sampled at the edge just passed
      if (pend_valid && pend_ready) begin
        exp_q.push_back(din);
        next_val = next_val + 12'h001;
      end
      if (prev_clk === 1'b1 && dac_clk === 1'b0) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
        n_cmp++; if (dac_data !== exp_v) begin n_bad++; $display("FAIL stream_fall cyc=%0d got=%h exp=%h", cyc, dac_data, exp_v); end
      end else begin
        n_cmp++; if (dac_data !== prev_data) begin n_bad++; $display("FAIL stream_stable cyc=%0d got=%h exp=%h", cyc, dac_data, prev_data); end
      end
      n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL stream_underrun cyc=%0d got=%b exp=0", cyc, underrun); end
      if (cyc >= 6) begin
        n_cmp++; if (level === 3'd0) begin n_bad++; $display("FAIL stream_level cyc=%0d got=0 exp=nonzero", cyc); end
      end
      prev_data = dac_data;
      prev_clk = dac_clk;
      din = next_val;
      din_valid = 1'b1;
      pend_valid = 1'b1;
      pend_ready = din_ready;
    end
    din_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] vals [5];
    vals[0] = 12'h111; vals[1] = 12'h222; vals[2] = 12'h333; vals[3] = 12'h444; vals[4] = 12'h555;
    reset_dut();
    din = vals[0];
    din_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_cyc(k);
      din = vals[k];
    end
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL fill_level4 got=%0d exp=4", level); end
    n_cmp++; if (din_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready0 got=%b exp=0", din_ready); end
    wait_cyc(5);
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL fill_hold_level got=%0d exp=4", level); end
    wait_cyc(6);
    n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL fill_pop_level got=%0d exp=3", level); end
    n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready1 got=%b exp=1", din_ready); end
    n_cmp++; if (dac_data !== 12'h111) begin n_bad++; $display("FAIL fill_first got=%h exp=111", dac_data); end
    wait_cyc(7);
    din_valid = 1'b0;
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL fill_refill got=%0d exp=4", level); end
    for (int p = 1; p <= 4; p++) begin
      wait_cyc(6 + 6 * p);
      n_cmp++; if (dac_data !== vals[p]) begin n_bad++; $display("FAIL fill_order p=%0d got=%h exp=%h", p, dac_data, vals[p]); end
    end
    n_cmp++; if (level !== 3'd0 || underrun !== 1'b0) begin n_bad++; $display("FAIL fill_drain got=%0d/%b exp=0/0", level, underrun); end
    wait_cyc(36);
    n_cmp++; if (underrun !== 1'b1 || dac_data !== 12'h555) begin n_bad++; $display("FAIL fill_underrun got=%b/%h exp=1/555", underrun, dac_data); end
  endtask

  task automatic test_collision_and_clear();
    reset_dut();
    wait_cyc(5);
    din = 12'hABC;
    din_valid = 1'b1;
    wait_cyc(6);
    din_valid = 1'b0;
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL coll_underrun got=%b exp=1", underrun); end
    n_cmp++; if (dac_data !== 12'h800) begin n_bad++; $display("FAIL coll_data got=%h exp=800", dac_data); end
    n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL coll_level got=%0d exp=1", level); end
    wait_cyc(11);
    n_cmp++; if (dac_data !== 12'h800) begin n_bad++; $display("FAIL coll_early got=%h exp=800", dac_data); end
    wait_cyc(12);
    n_cmp++; if (dac_data !== 12'hABC || level !== 3'd0) begin n_bad++; $display("FAIL coll_out got=%h/%0d exp=abc/0", dac_data, level); end
    din = 12'h123;
    din_valid = 1'b1;
    wait_cyc(13);
    din_valid = 1'b0;
    clr_underrun = 1'b1;
    wait_cyc(14);
    clr_underrun = 1'b0;
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL clr_nonempty got=%b exp=0", underrun); end
    wait_cyc(18);
    n_cmp++; if (underrun !== 1'b0 || dac_data !== 12'h123) begin n_bad++; $display("FAIL clr_pop got=%b/%h exp=0/123", underrun, dac_data); end
    wait_cyc(23);
    clr_underrun = 1'b1;
    wait_cyc(24);
    clr_underrun = 1'b0;
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL clr_set_wins got=%b exp=1", underrun); end
    wait_cyc(25);
    clr_underrun = 1'b1;
    wait_cyc(26);
    clr_underrun = 1'b0;
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL clr_plain got=%b exp=0", underrun); end
  endtask

  task automatic test_midrun_reset();
    logic exp_clk;
    reset_dut();
    din = 12'h101;
    din_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_cyc(k);
      din = din + 12'h001;
    end
    din_valid = 1'b0;
    wait_cyc(9);
    n_cmp++; if (dac_clk !== 1'b1 || level !== 3'd3 || dac_data !== 12'h101) begin n_bad++; $display("FAIL mid_pre got=%b/%0d/%h exp=1/3/101", dac_clk, level, dac_data); end
    CR = 1'b1;
    #1;
    n_cmp++; if (dac_clk !== 1'b0) begin n_bad++; $display("FAIL mid_dac_clk got=%b exp=0", dac_clk); end
    n_cmp++; if (dac_data !== 12'h800) begin n_bad++; $display("FAIL mid_dac_data got=%h exp=800", dac_data); end
    n_cmp++; if (level !== 3'd0 || din_ready !== 1'b1) begin n_bad++; $display("FAIL mid_level got=%0d/%b exp=0/1", level, din_ready); end
    repeat (2) @(negedge clk);
    CR = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      wait_cyc(k);
      exp_clk = ((k / 3) % 2) == 1;
      n_cmp++; if (dac_clk !== exp_clk) begin n_bad++; $display("FAIL mid_dac_clk_t cyc=%0d got=%b exp=%b", k, dac_clk, exp_clk); end
      n_cmp++; if (underrun !== (k >= 6) || dac_data !== 12'h800) begin n_bad++; $display("FAIL mid_restart cyc=%0d got=%b/%h exp=%b/800", k, underrun, dac_data, (k >= 6)); end
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_streaming();
    test_back_to_back();
    test_collision_and_clear();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
